hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard controller. It produces the forwarding selects consumed by the EX-stage source A/B operand muxes.
- It also produces stall and flush controls for all pipeline registers.
- It tracks data-memory wait cycles with a small FSM, a timeout checker and performance counters.
- It sits beside the 5-stage datapath, and takes register indices and control bits from the D/E/M/W pipeline registers.

Parameters:
- MEM_TIMEOUT, 64: max consecutive data-memory wait cycles before the timeout error flag sets.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- Rs1E  in  5  source register 1 of the instruction in EX.
- Rs2E  in  5  source register 2 of the instruction in EX.
- RdM  in  5  destination register of the instruction in MEM.
- RegWriteM  in  1  the MEM instruction writes the register file.
- RdW  in  5  destination register of the instruction in WB.
- RegWriteW  in  1  the WB instruction writes the register file.
- PCSrcE  in  1  taken branch/jump resolved in EX.
- DMemReqM  in  1  load/store access active in MEM.
- DMemReadyM  in  1  data memory completes the access this cycle.
- ForwardAE  out  2  source A select: 00 regfile, 01 WB, 10 MEM.
- ForwardBE  out  2  source B select, same encoding.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- StallE  out  1  hold ID/EX register.
- StallM  out  1  hold EX/MEM register.
- StallW  out  1  hold MEM/WB register.
- FlushD  out  1  clear IF/ID register to a bubble.
- FlushE  out  1  clear ID/EX register to a bubble.
- MemTimeoutErr  out  1  sticky timeout error flag.
- StallCycles  out  CNT_W  count of memory-stall cycles, saturating.
- FlushCount  out  CNT_W  count of branch-flush cycles, saturating.

Behaviour:
- **Reset**
  - Synchronous, active-high reset on rising clk. Reset state: FSM=RUN, wait_cnt=0, MemTimeoutErr=0, StallCycles=0, FlushCount=0.
  - While reset=1, outputs are forced: ForwardAE=ForwardBE=00, all Stall*=0, FlushD=FlushE=1 (drains bubbles into the pipeline).
  - Reset mid-wait aborts MEM_WAIT immediately; the timeout flag clears.
- **Forwarding** (combinational, zero latency, independent of FSM state)
  - ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE=00. ForwardBE follows the same rules with Rs2E.
  - MEM has priority over WB when both match. x0 never forwards.
  - Load data in MEM is forwarded by the operand mux itself, so no load-use stall is generated here.
- **MemStall**
  - MemStall = DMemReqM & ~DMemReadyM in RUN; MemStall = ~DMemReadyM in MEM_WAIT.
  - It is combinational and applies in the same cycle.
  - While MemStall=1: StallF=StallD=StallE=StallM=StallW=1.
  - WB is held rather than bubbled, so ResultW stays valid for forwarding. The repeated register-file write is idempotent.
- **FSM**
  - RUN -> MEM_WAIT when DMemReqM & ~DMemReadyM.
  - MEM_WAIT -> RUN on the cycle DMemReadyM=1. Stalls drop in that same cycle.
  - A ready in the first cycle (DMemReqM & DMemReadyM in RUN) causes no stall and no state change.
- **Timeout**
  - wait_cnt clears on entry to MEM_WAIT and increments each MEM_WAIT cycle, saturating.
  - When wait_cnt reaches MEM_TIMEOUT-1 with ~DMemReadyM, MemTimeoutErr sets on the next edge.
  - The flag is sticky until reset. The FSM keeps waiting; the flag is diagnostic only.
- **Flush**
  - FlushD = FlushE = PCSrcE & ~MemStall (outside reset).
  - If PCSrcE and MemStall coincide, the stall wins. EX is held, so PCSrcE persists and the flush occurs on the release cycle.
- **Counters**
  - StallCycles increments on every cycle with MemStall=1.
  - FlushCount increments on every non-reset cycle with FlushE=1.
  - Both saturate at 2^CNT_W-1 and never wrap.

Test Plan:
1. Forward priority: Rs1E=5; RdM=5, RegWriteM=1; RdW=5, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then Rs1E=RdM=RdW=0 -> ForwardAE=00.
2. Memory wait: DMemReqM=1, DMemReadyM=0 for 3 cycles, then 1 -> all Stall*=1 for exactly 3 cycles, then 0 in the ready cycle; StallCycles=3; FSM back in RUN.
3. Branch during stall: PCSrcE=1 with a 2-cycle memory wait -> FlushD/FlushE=0 during the stall, =1 in the release cycle; FlushCount=1.
4. Timeout: MEM_TIMEOUT=4, DMemReadyM held 0 for 6 cycles -> MemTimeoutErr rises after the 4th wait cycle and stays 1 after ready. A later reset clears it.
5. Reset mid-wait: reset asserted in cycle 2 of MEM_WAIT -> next cycle FSM=RUN, Stall*=0, FlushD=FlushE=1 while reset=1, counters=0.
6. Counter saturation: CNT_W=3, 10 stall cycles -> StallCycles=7 with no wrap.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard controller: EX operand forwarding, pipeline stall/flush control,
// data-memory wait FSM with timeout flag and saturating perf counters.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             DMemReqM,
  input  logic             DMemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MemTimeoutErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);

  state_t          state;
  state_t          nextState;
  logic [WW-1:0]   waitCnt;
  logic            memStall;
  logic            stallAll;
  logic            flushAll;

  // MEM beats WB; x0 is hardwired zero so it never forwards
  function automatic logic [1:0] fwdSel(
    input logic [4:0] rs,
    input logic [4:0] rdM,
    input logic       weM,
    input logic [4:0] rdW,
    input logic       weW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (weM && rdM != 5'd0 && rdM == rs)
      sel = 2'b10;
    else if (weW && rdW != 5'd0 && rdW == rs)
      sel = 2'b01;
    return sel;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      RUN:
        if (DMemReqM && !DMemReadyM)
          nextState = MEM_WAIT;
      MEM_WAIT:
        if (DMemReadyM)
          nextState = RUN;
      default:
        nextState = RUN;
    endcase
  end

  always_comb begin
    memStall = 1'b0;
    unique case (state)
      RUN:      memStall = DMemReqM & ~DMemReadyM;
      MEM_WAIT: memStall = ~DMemReadyM;
      default:  memStall = 1'b0;
    endcase
    stallAll  = memStall & ~reset;
    // stall wins over a branch; held EX replays PCSrcE on release
    flushAll  = reset | (PCSrcE & ~memStall);
    StallF    = stallAll;
    StallD    = stallAll;
    StallE    = stallAll;
    StallM    = stallAll;
    StallW    = stallAll;
    FlushD    = flushAll;
    FlushE    = flushAll;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      waitCnt <= '0;
    else if (state == RUN)
      waitCnt <= '0;
    else if (waitCnt != '1)
      waitCnt <= waitCnt + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      MemTimeoutErr <= 1'b0;
    else if (state == MEM_WAIT && !DMemReadyM && waitCnt == LAST)
      MemTimeoutErr <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      StallCycles <= '0;
    else if (stallAll && StallCycles != '1)
      StallCycles <= StallCycles + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      FlushCount <= '0;
    else if (flushAll && FlushCount != '1)
      FlushCount <= FlushCount + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, memory wait, branch/stall
// interaction, timeout, reset mid-wait and counter saturation.
module tb_hazard_unit;

  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic [4:0]    Rs1E;
  logic [4:0]    Rs2E;
  logic [4:0]    RdM;
  logic          RegWriteM;
  logic [4:0]    RdW;
  logic          RegWriteW;
  logic          PCSrcE;
  logic          DMemReqM;
  logic          DMemReadyM;
  logic [1:0]    ForwardAE;
  logic [1:0]    ForwardBE;
  logic          StallF;
  logic          StallD;
  logic          StallE;
  logic          StallM;
  logic          StallW;
  logic          FlushD;
  logic          FlushE;
  logic          MemTimeoutErr;
  logic [CW-1:0] StallCycles;
  logic [CW-1:0] FlushCount;

  int total = 0;
  int passed = 0;

  hazard_unit #(
    .MEM_TIMEOUT(4),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Rs1E(Rs1E),
    .Rs2E(Rs2E),
    .RdM(RdM),
    .RegWriteM(RegWriteM),
    .RdW(RdW),
    .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE),
    .DMemReqM(DMemReqM),
    .DMemReadyM(DMemReadyM),
    .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE),
    .StallF(StallF),
    .StallD(StallD),
    .StallE(StallE),
    .StallM(StallM),
    .StallW(StallW),
    .FlushD(FlushD),
    .FlushE(FlushE),
    .MemTimeoutErr(MemTimeoutErr),
    .StallCycles(StallCycles),
    .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] stalls();
    return {StallF, StallD, StallE, StallM, StallW};
  endfunction

  function automatic logic [1:0] flushes();
    return {FlushD, FlushE};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    PCSrcE = 1'b0;
    DMemReqM = 1'b0;
    DMemReadyM = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Rs1E = 5'd5; Rs2E = 5'd6;
    RdM = 5'd5; RegWriteM = 1'b1;
    RdW = 5'd6; RegWriteW = 1'b1;
    PCSrcE = 1'b0;
    DMemReqM = 1'b1; DMemReadyM = 1'b0;
    step(); step();
    #1;
    total++;
    if ({ForwardAE, ForwardBE} !== 4'b0000)
      $display("FAIL rst_fwd got %b exp 0000", {ForwardAE, ForwardBE});
    else passed++;
    total++;
    if (stalls() !== 5'b00000)
      $display("FAIL rst_stall got %b exp 00000", stalls());
    else passed++;
    total++;
    if (flushes() !== 2'b11)
      $display("FAIL rst_flush got %b exp 11", flushes());
    else passed++;
    total++;
    if ({MemTimeoutErr, StallCycles, FlushCount} !== 7'd0)
      $display("FAIL rst_regs got %b exp 0",
               {MemTimeoutErr, StallCycles, FlushCount});
    else passed++;
    DMemReqM = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (flushes() !== 2'b00)
      $display("FAIL rst_release_flush got %b exp 00", flushes());
    else passed++;
  endtask

  task automatic test_forward();
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    RdW = 5'd5; RegWriteW = 1'b1;
    Rs2E = 5'd7;
    #1;
    total++;
    if (ForwardAE !== 2'b10)
      $display("FAIL fwd_mem_prio got %b exp 10", ForwardAE);
    else passed++;
    total++;
    if (ForwardBE !== 2'b00)
      $display("FAIL fwd_b_nomatch got %b exp 00", ForwardBE);
    else passed++;
    RegWriteM = 1'b0;
    #1;
    total++;
    if (ForwardAE !== 2'b01)
      $display("FAIL fwd_wb got %b exp 01", ForwardAE);
    else passed++;
    RegWriteM = 1'b1;
    Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0;
    #1;
    total++;
    if (ForwardAE !== 2'b00)
      $display("FAIL fwd_x0 got %b exp 00", ForwardAE);
    else passed++;
    Rs2E = 5'd7; RdM = 5'd3; RdW = 5'd7;
    #1;
    total++;
    if (ForwardBE !== 2'b01)
      $display("FAIL fwdB_wb got %b exp 01", ForwardBE);
    else passed++;
    RdM = 5'd7;
    #1;
    total++;
    if (ForwardBE !== 2'b10)
      $display("FAIL fwdB_mem got %b exp 10", ForwardBE);
    else passed++;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  task automatic test_mem_wait();
    doReset();
    DMemReqM = 1'b1; DMemReadyM = 1'b1;
    #1;
    total++;
    if (stalls() !== 5'b00000)
      $display("FAIL first_ready got %b exp 00000", stalls());
    else passed++;
    step();
    DMemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (stalls() !== 5'b11111)
        $display("FAIL wait_stall%0d got %b exp 11111", i, stalls());
      else passed++;
      step();
    end
    DMemReadyM = 1'b1;
    #1;
    total++;
    if (stalls() !== 5'b00000)
      $display("FAIL wait_release got %b exp 00000", stalls());
    else passed++;
    step();
    DMemReqM = 1'b0; DMemReadyM = 1'b0;
    #1;
    total++;
    if (stalls() !== 5'b00000)
      $display("FAIL back_in_run got %b exp 00000", stalls());
    else passed++;
    total++;
    if (StallCycles !== 3'd3)
      $display("FAIL stall_count got %0d exp 3", StallCycles);
    else passed++;
  endtask

  task automatic test_branch_stall();
    doReset();
    PCSrcE = 1'b1; DMemReqM = 1'b1; DMemReadyM = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if ({flushes(), stalls()} !== 7'b00_11111)
        $display("FAIL br_stall%0d got %b exp 0011111",
                 i, {flushes(), stalls()});
      else passed++;
      step();
    end
    DMemReadyM = 1'b1;
    #1;
    total++;
    if ({flushes(), stalls()} !== 7'b11_00000)
      $display("FAIL br_release got %b exp 1100000",
               {flushes(), stalls()});
    else passed++;
    step();
    PCSrcE = 1'b0; DMemReqM = 1'b0; DMemReadyM = 1'b0;
    #1;
    total++;
    if (FlushCount !== 3'd1)
      $display("FAIL flush_count got %0d exp 1", FlushCount);
    else passed++;
    total++;
    if (StallCycles !== 3'd2)
      $display("FAIL br_stall_count got %0d exp 2", StallCycles);
    else passed++;
  endtask

  task automatic test_timeout();
    doReset();
    DMemReqM = 1'b1; DMemReadyM = 1'b0;
    step(); step(); step();
    total++;
    if (MemTimeoutErr !== 1'b0)
      $display("FAIL tmo_early got %b exp 0", MemTimeoutErr);
    else passed++;
    step(); step(); step();
    total++;
    if (MemTimeoutErr !== 1'b1)
      $display("FAIL tmo_set got %b exp 1", MemTimeoutErr);
    else passed++;
    DMemReadyM = 1'b1;
    step();
    DMemReqM = 1'b0; DMemReadyM = 1'b0;
    step();
    total++;
    if (MemTimeoutErr !== 1'b1)
      $display("FAIL tmo_sticky got %b exp 1", MemTimeoutErr);
    else passed++;
    doReset();
    total++;
    if (MemTimeoutErr !== 1'b0)
      $display("FAIL tmo_clear got %b exp 0", MemTimeoutErr);
    else passed++;
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    DMemReqM = 1'b1; DMemReadyM = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    total++;
    if ({flushes(), stalls()} !== 7'b11_00000)
      $display("FAIL rmw_forced got %b exp 1100000",
               {flushes(), stalls()});
    else passed++;
    step();
    total++;
    if ({StallCycles, FlushCount} !== 6'd0)
      $display("FAIL rmw_counters got %b exp 000000",
               {StallCycles, FlushCount});
    else passed++;
    DMemReqM = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (stalls() !== 5'b00000)
      $display("FAIL rmw_run got %b exp 00000", stalls());
    else passed++;
  endtask

  task automatic test_saturation();
    doReset();
    DMemReqM = 1'b1; DMemReadyM = 1'b0;
    for (int i = 0; i < 6; i++) step();
    total++;
    if (StallCycles !== 3'd6)
      $display("FAIL sat_mid got %0d exp 6", StallCycles);
    else passed++;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (StallCycles !== 3'd7)
      $display("FAIL sat_stall got %0d exp 7", StallCycles);
    else passed++;
    DMemReadyM = 1'b1;
    step();
    DMemReqM = 1'b0; DMemReadyM = 1'b0;
    PCSrcE = 1'b1;
    for (int i = 0; i < 9; i++) step();
    PCSrcE = 1'b0;
    #1;
    total++;
    if (FlushCount !== 3'd7)
      $display("FAIL sat_flush got %0d exp 7", FlushCount);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    Rs1E = '0; Rs2E = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0; DMemReqM = 1'b0; DMemReadyM = 1'b0;
    #1;
    test_reset();
    test_forward();
    test_mem_wait();
    test_branch_stall();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
